traffic_request_conditioner: RTL

// Upstream stage of the intersection signal controller. Conditions raw inputs:
//  - 4 vehicle-approach sensors and 2 pedestrian push-buttons.
//  - Per input: synchronise, then debounce.

---
 rtl/traffic_request_conditioner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/traffic_request_conditioner.sv
// Input conditioner for the intersection controller: syncs and debounces sensors and ped buttons,
// latches per-axis requests and flags long waits. Optional stats ports under TRAFFIC_REQ_STATS_EN.
module traffic_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_WAIT        = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sens_raw,
    input  logic [1:0] ped_raw,
    input  logic       clr_ns,
    input  logic       clr_ew,
    input  logic [1:0] clr_ped,
    output logic [3:0] sens_clean,
    output logic       ns_req,
    output logic       ew_req,
    output logic [1:0] ped_req,
    output logic       ns_urgent,
    output logic       ew_urgent
`ifdef TRAFFIC_REQ_STATS_EN
    ,
    output logic [7:0] ns_req_count,
    output logic [7:0] ew_req_count
`endif
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    // Bits [3:0] are the approach sensors, [5:4] the ped buttons.
    logic [5:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [5:0]         clean_q, clean_d, clean_prev_q, clean_prev_d;
    logic [5:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic [5:0]         rise;
    logic               ns_req_q, ns_req_d, ew_req_q, ew_req_d;
    logic [1:0]         ped_req_q, ped_req_d;
    logic [WW-1:0]      ns_wait_q, ns_wait_d, ew_wait_q, ew_wait_d;

    assign rise = clean_q & ~clean_prev_q;

    always_comb begin
        sync1_d      = {ped_raw, sens_raw};
        sync2_d      = sync1_q;
        clean_prev_d = clean_q;
        clean_d      = clean_q;
        db_cnt_d     = db_cnt_q;
        for (int i = 0; i < 6; i++) begin
            if (sync2_q[i] != clean_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    clean_d[i]  = ~clean_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end

        // A clear while the axis is still occupied re-arms immediately.
        ns_req_d  = (ns_req_q & ~clr_ns) | rise[0] | rise[1] | (clr_ns & (clean_q[0] | clean_q[1]));
        ew_req_d  = (ew_req_q & ~clr_ew) | rise[2] | rise[3] | (clr_ew & (clean_q[2] | clean_q[3]));
        ped_req_d = (ped_req_q & ~clr_ped) | rise[5:4];

        ns_wait_d = '0;
        if (ns_req_q && ns_req_d)
            ns_wait_d = (ns_wait_q == WAIT_MAX) ? ns_wait_q : ns_wait_q + 1'b1;
        ew_wait_d = '0;
        if (ew_req_q && ew_req_d)
            ew_wait_d = (ew_wait_q == WAIT_MAX) ? ew_wait_q : ew_wait_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            clean_q      <= '0;
            clean_prev_q <= '0;
            db_cnt_q     <= '0;
            ns_req_q     <= 1'b0;
            ew_req_q     <= 1'b0;
            ped_req_q    <= '0;
            ns_wait_q    <= '0;
            ew_wait_q    <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            clean_q      <= clean_d;
            clean_prev_q <= clean_prev_d;
            db_cnt_q     <= db_cnt_d;
            ns_req_q     <= ns_req_d;
            ew_req_q     <= ew_req_d;
            ped_req_q    <= ped_req_d;
            ns_wait_q    <= ns_wait_d;
            ew_wait_q    <= ew_wait_d;
        end
    end

    assign sens_clean = clean_q[3:0];
    assign ns_req     = ns_req_q;
    assign ew_req     = ew_req_q;
    assign ped_req    = ped_req_q;
    assign ns_urgent  = ns_req_q & (ns_wait_q == WAIT_MAX);
    assign ew_urgent  = ew_req_q & (ew_wait_q == WAIT_MAX);

`ifdef TRAFFIC_REQ_STATS_EN
    logic [7:0] ns_cnt_q, ns_cnt_d, ew_cnt_q, ew_cnt_d;

    always_comb begin
        ns_cnt_d = ns_cnt_q;
        ew_cnt_d = ew_cnt_q;
        if (ns_req_d && !ns_req_q && ns_cnt_q != 8'hFF) ns_cnt_d = ns_cnt_q + 8'd1;
        if (ew_req_d && !ew_req_q && ew_cnt_q != 8'hFF) ew_cnt_d = ew_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ns_cnt_q <= '0;
            ew_cnt_q <= '0;
        end else begin
            ns_cnt_q <= ns_cnt_d;
            ew_cnt_q <= ew_cnt_d;
        end
    end

    assign ns_req_count = ns_cnt_q;
    assign ew_req_count = ew_cnt_q;
`endif

endmodule
